// File: rtl/sd_cmd_arbiter.sv
// SD host command-path arbiter: shares cmd_set/cmd_arg issue between
// software and data-master requesters, supervises busy, routes completion.
module sd_cmd_arbiter #(
  parameter int START_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_req,
  input  logic [15:0] sw_cmd,
  input  logic [31:0] sw_arg,
  output logic        sw_ack,
  output logic        sw_done,
  output logic        sw_err,
  input  logic        dm_req,
  input  logic        dm_urgent,
  input  logic [15:0] dm_cmd,
  input  logic [31:0] dm_arg,
  output logic        dm_ack,
  output logic        dm_done,
  output logic        dm_err,
  output logic [15:0] cmd_set,
  output logic [31:0] cmd_arg,
  output logic        cmd_start,
  input  logic        cmd_busy,
  input  logic        cmd_tsf_err,
  output logic        owner,
  output logic        arb_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(START_TIMEOUT - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;
  logic               r_owner;
  logic               r_sw_ack;
  logic               r_sw_done;
  logic               r_sw_err;
  logic               r_dm_ack;
  logic               r_dm_done;
  logic               r_dm_err;
  logic [15:0]        r_cmd_set;
  logic [31:0]        r_cmd_arg;
  logic               r_start;
  logic               r_busy;

  logic w_gnt_dm;
  logic w_gnt_sw;

  // Urgent dm always wins; on a plain tie the last loser goes next.
  assign w_gnt_dm = dm_req & ~cmd_busy &
                    (dm_urgent | ~sw_req | ~r_last);
  assign w_gnt_sw = sw_req & ~cmd_busy & ~w_gnt_dm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_sw_ack  <= 1'b0;
      r_sw_done <= 1'b0;
      r_sw_err  <= 1'b0;
      r_dm_ack  <= 1'b0;
      r_dm_done <= 1'b0;
      r_dm_err  <= 1'b0;
      r_cmd_set <= '0;
      r_cmd_arg <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sw_ack  <= 1'b0;
      r_dm_ack  <= 1'b0;
      r_sw_done <= 1'b0;
      r_dm_done <= 1'b0;
      r_sw_err  <= 1'b0;
      r_dm_err  <= 1'b0;
      r_start   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_dm | w_gnt_sw) begin
            r_cmd_set <= w_gnt_dm ? dm_cmd : sw_cmd;
            r_cmd_arg <= w_gnt_dm ? dm_arg : sw_arg;
            r_owner   <= w_gnt_dm;
            r_dm_ack  <= w_gnt_dm;
            r_sw_ack  <= w_gnt_sw;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (cmd_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == LP_LAST) begin
            r_sw_done <= ~r_owner;
            r_dm_done <= r_owner;
            r_sw_err  <= ~r_owner;
            r_dm_err  <= r_owner;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!cmd_busy) begin
            r_sw_done <= ~r_owner;
            r_dm_done <= r_owner;
            r_sw_err  <= ~r_owner & cmd_tsf_err;
            r_dm_err  <= r_owner & cmd_tsf_err;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_last  <= r_owner;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sw_ack    = r_sw_ack;
  assign sw_done   = r_sw_done;
  assign sw_err    = r_sw_err;
  assign dm_ack    = r_dm_ack;
  assign dm_done   = r_dm_done;
  assign dm_err    = r_dm_err;
  assign cmd_set   = r_cmd_set;
  assign cmd_arg   = r_cmd_arg;
  assign cmd_start = r_start;
  assign owner     = r_owner;
  assign arb_busy  = r_busy;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Scoreboard bench for sd_cmd_arbiter: random request rounds against a
// grant-order model, plus a command-host responder.
module tb_sd_cmd_arbiter;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw_req, dm_req, dm_urgent;
  logic [15:0] sw_cmd, dm_cmd;
  logic [31:0] sw_arg, dm_arg;
  logic        sw_ack, sw_done, sw_err;
  logic        dm_ack, dm_done, dm_err;
  logic [15:0] cmd_set;
  logic [31:0] cmd_arg;
  logic        cmd_start, cmd_busy, cmd_tsf_err;
  logic        owner, arb_busy;

  sd_cmd_arbiter #(.START_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .sw_req(sw_req), .sw_cmd(sw_cmd), .sw_arg(sw_arg),
    .sw_ack(sw_ack), .sw_done(sw_done), .sw_err(sw_err),
    .dm_req(dm_req), .dm_urgent(dm_urgent),
    .dm_cmd(dm_cmd), .dm_arg(dm_arg),
    .dm_ack(dm_ack), .dm_done(dm_done), .dm_err(dm_err),
    .cmd_set(cmd_set), .cmd_arg(cmd_arg),
    .cmd_start(cmd_start), .cmd_busy(cmd_busy),
    .cmd_tsf_err(cmd_tsf_err),
    .owner(owner), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          own;
    logic [15:0] cmd;
    logic [31:0] arg;
    int          dly;
    int          len;
    bit          tsf;
    bit          tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t host_e;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ack_cyc = 0;
  int   start_cyc = 0;
  bit   m_last = 1'b1;
  logic pb = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {7'd0, sw_ack, sw_done, sw_err,
            dm_ack, dm_done, dm_err,
            cmd_set, cmd_arg, cmd_start, owner, arb_busy};
  endfunction

  function automatic exp_t mk();
    exp_t e;
    e.own = 1'b0;
    e.cmd = 16'($urandom);
    e.arg = $urandom;
    e.dly = $urandom_range(1, 5);
    e.len = $urandom_range(1, 10);
    e.tsf = 1'($urandom_range(0, 1));
    e.tmo = ($urandom_range(0, 9) == 0);
    return e;
  endfunction

  // Command host: answers each issued command as the front entry says.
  initial begin
    cmd_busy = 1'b0;
    cmd_tsf_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && cmd_start && exp_q.size() != 0) begin
        host_e = exp_q[0];
        if (!host_e.tmo) begin
          repeat (host_e.dly) @(posedge clk);
          #1 cmd_busy = 1'b1;
          repeat (host_e.len) @(posedge clk);
          #1 cmd_busy = 1'b0;
          cmd_tsf_err = host_e.tsf;
          @(posedge clk);
          #1 cmd_tsf_err = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every ack/start/done against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (sw_ack || dm_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexp_ack", {sw_ack, dm_ack}, 0);
        end else begin
          chk("ack_who", {sw_ack, dm_ack},
              exp_q[0].own ? 2'b01 : 2'b10);
          chk("ack_cmd", cmd_set, exp_q[0].cmd);
          chk("ack_arg", cmd_arg, exp_q[0].arg);
          chk("ack_owner", owner, exp_q[0].own);
          chk("ack_busy_gate", pb, 0);
          chk("ack_arb_busy", arb_busy, 1);
          ack_cyc = cyc;
        end
      end
      if (cmd_start) begin
        if (exp_q.size() == 0) begin
          chk("unexp_start", cmd_start, 0);
        end else begin
          chk("start_lat", cyc - ack_cyc, 1);
          chk("start_cmd", cmd_set, exp_q[0].cmd);
          start_cyc = cyc;
        end
      end
      if (sw_done || dm_done) begin
        if (exp_q.size() == 0) begin
          chk("unexp_done", {sw_done, dm_done}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_who", {sw_done, dm_done},
              mon_e.own ? 2'b01 : 2'b10);
          chk("done_err", {sw_err, dm_err},
              mon_e.own ? {1'b0, mon_e.tmo | mon_e.tsf}
                        : {mon_e.tmo | mon_e.tsf, 1'b0});
          chk("done_hold", {cmd_set, cmd_arg},
              {mon_e.cmd, mon_e.arg});
          if (mon_e.tmo)
            chk("tmo_lat", cyc - start_cyc, TMO);
        end
      end
    end
    pb = cmd_busy;
  end

  task automatic drive_sw(input logic [15:0] c,
                          input logic [31:0] a);
    bit ok = 1'b0;
    @(posedge clk);
    #1 sw_req = 1'b1;
    sw_cmd = c;
    sw_arg = a;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sw_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("sw_ack_seen", ok, 1);
    @(posedge clk);
    #1 sw_req = 1'b0;
    sw_cmd = 16'($urandom);
    sw_arg = $urandom;
  endtask

  task automatic drive_dm(input logic [15:0] c,
                          input logic [31:0] a,
                          input bit u);
    bit ok = 1'b0;
    @(posedge clk);
    #1 dm_req = 1'b1;
    dm_urgent = u;
    dm_cmd = c;
    dm_arg = a;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dm_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("dm_ack_seen", ok, 1);
    @(posedge clk);
    #1 dm_req = 1'b0;
    dm_urgent = 1'b0;
    dm_cmd = 16'($urandom);
    dm_arg = $urandom;
  endtask

  task automatic round(input bit s, input bit d, input bit urg,
                       input exp_t es, input exp_t ed);
    bit dm_first;
    es.own = 1'b0;
    ed.own = 1'b1;
    if (s && d) begin
      dm_first = urg || (m_last == 1'b0);
      if (dm_first) begin
        exp_q.push_back(ed);
        exp_q.push_back(es);
        m_last = 1'b0;
      end else begin
        exp_q.push_back(es);
        exp_q.push_back(ed);
        m_last = 1'b1;
      end
    end else if (s) begin
      exp_q.push_back(es);
      m_last = 1'b0;
      dm_urgent = urg;
    end else begin
      exp_q.push_back(ed);
      m_last = 1'b1;
    end
    fork
      begin if (s) drive_sw(es.cmd, es.arg); end
      begin if (d) drive_dm(ed.cmd, ed.arg, urg); end
    join
    dm_urgent = 1'b0;
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++)
      @(posedge clk);
    chk("round_drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 chk("idle_arb_busy", arb_busy, 0);
  endtask

  initial begin
    exp_t es, ed;
    bit s, d;
    rst = 1'b1;
    sw_req = 1'b0; dm_req = 1'b0; dm_urgent = 1'b0;
    sw_cmd = '0; sw_arg = '0; dm_cmd = '0; dm_arg = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", outs(), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_outs", outs(), 0);

    // Tie after reset: sw, dm; then again sw, dm.
    round(1, 1, 0, mk(), mk());
    round(1, 1, 0, mk(), mk());

    es = mk();
    es.cmd = 16'h081A; es.arg = 32'h1AA;
    es.dly = 3; es.len = 10; es.tsf = 0; es.tmo = 0;
    round(1, 0, 0, es, mk());

    // Urgent dm wins with last grant sw, then with last grant dm.
    ed = mk(); ed.cmd = 16'h0C1A;
    round(1, 1, 1, mk(), ed);
    round(0, 1, 0, es, mk());
    ed = mk(); ed.cmd = 16'h0C1A;
    round(1, 1, 1, mk(), ed);

    // Urgent without request is ignored.
    round(1, 0, 1, mk(), mk());

    es = mk(); es.tmo = 1;
    round(1, 0, 0, es, mk());

    ed = mk(); ed.tmo = 0; ed.tsf = 1;
    round(0, 1, 0, mk(), ed);
    es = mk(); es.tmo = 0; es.tsf = 0;
    round(1, 0, 0, es, mk());

    // Reset while the host is busy with an sw command.
    es = mk(); es.own = 0; es.dly = 2; es.len = 40;
    es.tmo = 0; es.tsf = 0;
    exp_q.push_back(es);
    m_last = 1'b0;
    drive_sw(es.cmd, es.arg);
    for (int i = 0; i < 50 && !cmd_busy; i++) @(posedge clk);
    chk("busy_rise", cmd_busy, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_mid_outs", outs(), 0);
    exp_q.delete();
    m_last = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rst_hold_outs", outs(), 0);
    rst = 1'b0;
    es = mk(); es.tmo = 0; es.tsf = 0;
    round(1, 0, 0, es, mk());

    for (int r = 0; r < 40; r++) begin
      s = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!s && !d) s = 1'b1;
      round(s, d, 1'($urandom_range(0, 1)), mk(), mk());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
